// File: rtl/idx_dec_32_pkg.sv
// idx_dec_32_pkg: shared constants and types for the spike-index decoder.
// Token layout is common with the sparse index encoder: {eof, idx[IW-1:0]}.
// Optional build macro used by this block: IDX_DEC_DUP_CHK_EN.
package idx_dec_32_pkg;

    // Shipped bitmap width.
    localparam int NB_DEF = 32;

    // Index width for a bitmap of nb bits (nb is a power of two, >= 2).
    function automatic int idx_w(input int nb);
        return (nb <= 2) ? 1 : $clog2(nb);
    endfunction

    // Token width: index bits plus the EOF flag on top.
    function automatic int tok_w(input int nb);
        return idx_w(nb) + 1;
    endfunction

    // Bit position of the EOF flag inside a token.
    function automatic int eof_bit(input int nb);
        return idx_w(nb);
    endfunction

    localparam int IW_DEF    = idx_w(NB_DEF);
    localparam int TOK_W_DEF = tok_w(NB_DEF);
    localparam int EOF_B_DEF = eof_bit(NB_DEF);

    // Token view for the shipped configuration.
    typedef struct packed {
        logic              eof;
        logic [IW_DEF-1:0] idx;
    } tok_t;

    // Output buffer occupancy.
    typedef enum logic {
        OB_EMPTY = 1'b0,
        OB_FULL  = 1'b1
    } ob_state_e;

endpackage

// File: rtl/idx_dec_32_acc.sv
// idx_dec_acc: frame accumulator. ORs each accepted index into acc and counts
// only bits that were previously clear, so repeated indices are idempotent.
// hit flags an accepted index whose bit was already set (for the dup checker).
module idx_dec_acc
    import idx_dec_32_pkg::*;
#(
    parameter  int NB = NB_DEF,
    localparam int IW = idx_w(NB)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          idx_vld,
    input  logic [IW-1:0] idx,
    input  logic          clr,
    output logic [NB-1:0] acc,
    output logic [IW:0]   acc_cnt,
    output logic          hit
);

    logic [NB-1:0] onehot;

    // One-hot decode of the incoming index, one comparator per bitmap bit.
    for (genvar b = 0; b < NB; b++) begin : g_oh
        assign onehot[b] = (idx == IW'(b));
    end

    assign hit = idx_vld & (|(acc & onehot));

    // Accumulate the frame; EOF (clr) empties it for the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else if (clr) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else if (idx_vld) begin
            acc <= acc | onehot;
            if (!hit)
                acc_cnt <= acc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/idx_dec_32.sv
// idx_dec_32: rebuilds the dense NB-bit spike bitmap from a stream of index
// tokens, one vector per frame, double-buffered against opt_ready.
// Build macro IDX_DEC_DUP_CHK_EN adds a sticky dup_err output.
module idx_dec_32
    import idx_dec_32_pkg::*;
#(
    parameter  int NB = NB_DEF,
    localparam int IW = idx_w(NB)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ipt_valid,
    output logic          ipt_ready,
    input  logic [IW:0]   enc,
    output logic          opt_valid,
    input  logic          opt_ready,
    output logic [NB-1:0] sparse_bits,
    output logic [IW:0]   spike_cnt
`ifdef IDX_DEC_DUP_CHK_EN
    ,
    output logic          dup_err
`endif
);

    ob_state_e     state_q, state_d;
    logic          is_eof;
    logic          tok_fire, eof_fire, idx_fire;
    logic [NB-1:0] acc;
    logic [IW:0]   acc_cnt;
    logic          dup_hit;

    assign is_eof = enc[IW];

    // Index tokens never stall; EOF waits only while the held vector is unread.
    assign ipt_ready = ~is_eof | ~opt_valid | opt_ready;
    assign tok_fire  = ipt_valid & ipt_ready;
    assign eof_fire  = tok_fire & is_eof;
    assign idx_fire  = tok_fire & ~is_eof;

    idx_dec_acc #(.NB(NB)) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .idx_vld (idx_fire),
        .idx     (enc[IW-1:0]),
        .clr     (eof_fire),
        .acc     (acc),
        .acc_cnt (acc_cnt),
        .hit     (dup_hit)
    );

    // Output buffer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= OB_EMPTY;
        else        state_q <= state_d;
    end

    // Next state: EOF fills (or refills on same-cycle handover), read empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OB_EMPTY: if (eof_fire) state_d = OB_FULL;
            OB_FULL: begin
                if (eof_fire)       state_d = OB_FULL;
                else if (opt_ready) state_d = OB_EMPTY;
            end
            default: state_d = OB_EMPTY;
        endcase
    end

    assign opt_valid = (state_q == OB_FULL);

    // Output vector and count captured on EOF; held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sparse_bits <= '0;
            spike_cnt   <= '0;
        end else if (eof_fire) begin
            sparse_bits <= acc;
            spike_cnt   <= acc_cnt;
        end
    end

`ifdef IDX_DEC_DUP_CHK_EN
    // Sticky duplicate-index flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)       dup_err <= 1'b0;
        else if (dup_hit) dup_err <= 1'b1;
    end
`else
    logic dup_unused;
    assign dup_unused = dup_hit;
`endif

endmodule
